// File: rtl/ringbuffer_ctl.sv
// Single-clock ring buffer between the LPC decoder and the UART/USB drain.
// Extended pointers give full-depth use; overflow policy is selected by MODE.
module ringbuffer_ctl #(
  parameter int AW       = 8,
  parameter int DW       = 48,
  parameter int MODE     = 0,
  parameter int AF_LEVEL = (32'sd1 << AW) - 32'sd4,
  parameter int LW       = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write_enable,
  input  logic [DW-1:0] write_data,
  input  logic          read_enable,
  output logic [DW-1:0] read_data,
  output logic          read_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          lost_clear,
  output logic [LW-1:0] lost_count
);

  localparam int            DEPTH_N     = 32'sd1 << AW;
  localparam logic [AW:0]   ZERO_C      = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_C       = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   DEPTH_C     = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   AF_C        = (AW+1)'(AF_LEVEL);
  localparam logic [LW-1:0] LOST_MAX_C  = {LW{1'b1}};
  localparam logic          OVERWRITE_C = (MODE == 32'sd1);

  logic [DW-1:0] mem_r [DEPTH_N];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [DW-1:0] read_data_r;
  logic          read_valid_r;
  logic          overflow_r;
  logic [LW-1:0] lost_count_r;

  logic [AW:0]   level_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          loss_s;
  logic          rd_adv_s;

  // Status flags and push/pop/loss decisions from the registered pointers.
  always_comb begin
    level_s  = wr_ptr_r - rd_ptr_r;
    empty_s  = (level_s == ZERO_C);
    full_s   = (level_s == DEPTH_C);
    pop_s    = read_enable & ~empty_s;
    loss_s   = write_enable & full_s & ~pop_s;
    push_s   = 1'b0;
    rd_adv_s = pop_s;
    if (OVERWRITE_C) begin
      // Overwrite-oldest: a push always lands; a loss drags the read pointer along.
      push_s   = write_enable;
      rd_adv_s = pop_s | loss_s;
    end else begin
      push_s   = write_enable & (~full_s | pop_s);
      rd_adv_s = pop_s;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= write_data;
    end
  end

  // Pointers, registered read port, overflow pulse and lost-word counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= ZERO_C;
      rd_ptr_r     <= ZERO_C;
      read_data_r  <= {DW{1'b0}};
      read_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      lost_count_r <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      // Non-blocking read of the old word gives read-before-write on a shared address.
      if (pop_s) begin
        read_data_r <= mem_r[rd_ptr_r[AW-1:0]];
      end
      read_valid_r <= pop_s;
      overflow_r   <= loss_s;
      if (lost_clear) begin
        lost_count_r <= {LW{1'b0}};
      end else if (loss_s && (lost_count_r != LOST_MAX_C)) begin
        lost_count_r <= lost_count_r + {{(LW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign read_data   = read_data_r;
  assign read_valid  = read_valid_r;
  assign level       = level_s;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (level_s >= AF_C);
  assign overflow    = overflow_r;
  assign lost_count  = lost_count_r;

endmodule

// File: tb/tb_ringbuffer_ctl.sv
// Directed bench for ringbuffer_ctl: three AW=3 instances (drop, overwrite,
// saturating 2-bit counter) plus a scoreboarded random stream on the drop instance.
module tb_ringbuffer_ctl;

  logic        clock = 1'b0;
  logic        reset;
  logic        we [3];
  logic        re [3];
  logic        lc [3];
  logic [15:0] wd [3];
  logic [15:0] rd [3];
  logic        rv [3];
  logic        emp [3];
  logic        ful [3];
  logic        af [3];
  logic        ov [3];
  logic [3:0]  lvl [3];
  logic [15:0] lost [2];
  logic [1:0]  lost_sat;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q [$];
  logic [15:0] exp_d;
  logic        pop_m;
  logic        push_m;
  logic        w_r;
  logic        r_r;
  logic [15:0] d_r;

  always #5 clock = ~clock;

  ringbuffer_ctl #(.AW(3), .DW(16), .MODE(0), .AF_LEVEL(6), .LW(16)) dut0 (
    .clock(clock), .reset(reset), .write_enable(we[0]), .write_data(wd[0]),
    .read_enable(re[0]), .read_data(rd[0]), .read_valid(rv[0]), .empty(emp[0]),
    .full(ful[0]), .almost_full(af[0]), .level(lvl[0]), .overflow(ov[0]),
    .lost_clear(lc[0]), .lost_count(lost[0]));

  ringbuffer_ctl #(.AW(3), .DW(16), .MODE(1), .AF_LEVEL(6), .LW(16)) dut1 (
    .clock(clock), .reset(reset), .write_enable(we[1]), .write_data(wd[1]),
    .read_enable(re[1]), .read_data(rd[1]), .read_valid(rv[1]), .empty(emp[1]),
    .full(ful[1]), .almost_full(af[1]), .level(lvl[1]), .overflow(ov[1]),
    .lost_clear(lc[1]), .lost_count(lost[1]));

  ringbuffer_ctl #(.AW(3), .DW(16), .MODE(0), .AF_LEVEL(6), .LW(2)) dut2 (
    .clock(clock), .reset(reset), .write_enable(we[2]), .write_data(wd[2]),
    .read_enable(re[2]), .read_data(rd[2]), .read_valid(rv[2]), .empty(emp[2]),
    .full(ful[2]), .almost_full(af[2]), .level(lvl[2]), .overflow(ov[2]),
    .lost_clear(lc[2]), .lost_count(lost_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input int k, input logic w, input logic [15:0] d,
                     input logic r, input logic c);
    we[k] = w;
    wd[k] = d;
    re[k] = r;
    lc[k] = c;
    tick();
    we[k] = 1'b0;
    re[k] = 1'b0;
    lc[k] = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0; re[k] = 1'b0; lc[k] = 1'b0; wd[k] = 16'h0000;
    end
    #3;
    chk("rst_level", lvl[0], 0);
    chk("rst_empty", emp[0], 1);
    chk("rst_full", ful[0], 0);
    chk("rst_af", af[0], 0);
    chk("rst_valid", rv[0], 0);
    chk("rst_data", rd[0], 0);
    chk("rst_ovf", ov[0], 0);
    chk("rst_lost", lost[0], 0);
    #9;
    reset = 1'b1;
    tick();

    // Fill and drain in order (drop mode).
    for (int i = 1; i <= 8; i++) cyc(0, 1'b1, 16'(i), 1'b0, 1'b0);
    chk("fill_level", lvl[0], 8);
    chk("fill_full", ful[0], 1);
    chk("fill_af", af[0], 1);
    chk("fill_empty", emp[0], 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("drain_valid", rv[0], 1);
      chk("drain_data", rd[0], i);
    end
    chk("drain_empty", emp[0], 1);
    tick();
    chk("idle_valid", rv[0], 0);
    chk("idle_hold", rd[0], 8);

    // Drop-newest on full, then push-with-pop at full.
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 16'(16'h11 + i), 1'b0, 1'b0);
    cyc(0, 1'b1, 16'h00AA, 1'b0, 1'b0);
    chk("drop_ovf", ov[0], 1);
    chk("drop_lost", lost[0], 1);
    chk("drop_level", lvl[0], 8);
    tick();
    chk("drop_ovf_end", ov[0], 0);
    cyc(0, 1'b1, 16'h00BB, 1'b1, 1'b0);
    chk("fullpp_valid", rv[0], 1);
    chk("fullpp_data", rd[0], 16'h11);
    chk("fullpp_level", lvl[0], 8);
    chk("fullpp_lost", lost[0], 1);
    chk("fullpp_ovf", ov[0], 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("drop_drain", rd[0], (i < 7) ? (16'h12 + i) : 16'hBB);
    end
    chk("drop_empty", emp[0], 1);

    // Empty corner cases.
    cyc(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("rdempty_valid", rv[0], 0);
    chk("rdempty_level", lvl[0], 0);
    cyc(0, 1'b1, 16'h0077, 1'b1, 1'b0);
    chk("ppempty_level", lvl[0], 1);
    chk("ppempty_valid", rv[0], 0);
    cyc(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("ppempty_data", rd[0], 16'h77);
    chk("ppempty_rv", rv[0], 1);

    // Overwrite-oldest mode with almost_full threshold 6.
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 1'b1, 16'(i), 1'b0, 1'b0);
      chk("ow_level", lvl[1], (i > 8) ? 8 : i);
      chk("ow_af", af[1], (i >= 6) ? 1 : 0);
      chk("ow_ovf", ov[1], (i > 8) ? 1 : 0);
    end
    chk("ow_lost", lost[1], 2);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("ow_drain", rd[1], i + 2);
    end
    chk("ow_empty", emp[1], 1);

    // Saturating 2-bit lost counter.
    for (int i = 0; i < 8; i++) cyc(2, 1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(2, 1'b1, 16'(16'hE0 + i), 1'b0, 1'b0);
      chk("sat_ovf", ov[2], 1);
      chk("sat_lost", lost_sat, (i > 3) ? 3 : i);
    end
    cyc(2, 1'b1, 16'h00EF, 1'b0, 1'b1);
    chk("clr_lost", lost_sat, 0);
    chk("clr_ovf", ov[2], 1);
    chk("clr_level", lvl[2], 8);

    // Random concurrent traffic against a queue model.
    cyc(0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("rnd_clr", lost[0], 0);
    q.delete();
    for (int n = 0; n < 1000; n++) begin
      w_r = 1'($urandom_range(0, 1));
      r_r = 1'($urandom_range(0, 1));
      d_r = 16'($urandom);
      pop_m  = r_r && (q.size() != 0);
      push_m = w_r && ((q.size() < 8) || pop_m);
      if (pop_m) exp_d = q.pop_front();
      if (push_m) q.push_back(d_r);
      cyc(0, w_r, d_r, r_r, 1'b0);
      chk("rnd_level", lvl[0], q.size());
      chk("rnd_valid", rv[0], pop_m);
      if (pop_m) chk("rnd_data", rd[0], exp_d);
    end

    // Asynchronous reset with a pop in flight.
    for (int i = 0; i < 5; i++) cyc(1, 1'b1, 16'(16'h31 + i), 1'b0, 1'b0);
    chk("mid_level", lvl[1], 5);
    cyc(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("mid_valid", rv[1], 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_empty", emp[1], 1);
    chk("arst_level", lvl[1], 0);
    chk("arst_valid", rv[1], 0);
    chk("arst_lost", lost[1], 0);
    chk("arst_data", rd[1], 0);
    chk("arst_lvl0", lvl[0], 0);
    #1;
    reset = 1'b1;
    cyc(1, 1'b1, 16'h0055, 1'b0, 1'b0);
    chk("resume_level", lvl[1], 1);
    cyc(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("resume_valid", rv[1], 1);
    chk("resume_data", rd[1], 16'h55);
    chk("resume_empty", emp[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
